alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal.
REQ-007 cmd_a, cmd_b  input  WIDTH  operands.
REQ-008 a, b  output  WIDTH  registered operands driven to the downstream ALU.
REQ-009 Binvert, Carryin  output  1  ALU b-invert and carry-in controls.
REQ-010 Operation  output  2  ALU select: 00 AND, 01 OR, 10 ADD.
REQ-011 Result  input  WIDTH  combinational ALU result; CarryOut  input  1  ALU carry-out.
REQ-012 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-013 rsp_result  output  WIDTH; rsp_carry, rsp_zero, rsp_ovf, rsp_err  output  1 each.

Function
REQ-014 States IDLE, EXEC, RESP; cmd_ready = 1 only in IDLE.
REQ-015 IDLE: cmd_valid & cmd_ready at edge N -> a, b, Binvert, Carryin, Operation registered at N, state EXEC.
REQ-016 Decode: AND 00/0/0; OR 01/0/0; ADD 10/0/0; SUB 10/1/1; SLT 10/1/1 (Operation/Binvert/Carryin).
REQ-017 Illegal opcode: ALU controls driven AND/0/0, rsp_result 0, rsp_err 1, other flags 0.
REQ-018 EXEC lasts exactly one cycle; at edge N+1 Result/CarryOut captured into rsp_* registers, state RESP; rsp_valid high from N+1.
REQ-019 rsp_carry = CarryOut for ADD/SUB/SLT, 0 for AND/OR.
REQ-020 rsp_ovf (ADD/SUB/SLT) = (a[MSB] == b'[MSB]) & (Result[MSB] != a[MSB]), b' = b inverted when Binvert; 0 for AND/OR.
REQ-021 SLT: rsp_result = {zeros, Result[MSB] ^ ovf}; rsp_carry, rsp_ovf reported as for SUB.
REQ-022 rsp_zero = (rsp_result == 0), computed on the final (post-SLT) result.
REQ-023 RESP: all rsp_* outputs held stable while rsp_ready = 0; rsp_valid & rsp_ready -> IDLE next edge.
REQ-024 Throughput one command per 3 cycles minimum; no command accepted in EXEC or RESP.
REQ-025 a, b, ALU controls hold last values outside IDLE-accept.

Reset
REQ-026 reset at any edge, any state -> IDLE; cmd_ready 1 after reset; a, b, Operation, Binvert, Carryin, rsp_valid, all rsp_* = 0.
REQ-027 Command in EXEC/RESP at reset is dropped; no response emitted.
REQ-028 reset dominates simultaneous cmd_valid or rsp_ready.

Configuration
REQ-029 Macro ALU_SEQ_SLT_EN defined: opcode 111 executes SLT per REQ-021.
REQ-030 ALU_SEQ_SLT_EN undefined: opcode 111 is illegal per REQ-017; no SLT logic synthesised.

Structure
REQ-031 Package alu_seq_pkg: opcode constants, ALU Operation constants, state encoding.
REQ-032 Sub-module alu_seq_decode: combinational cmd_op -> Operation/Binvert/Carryin/illegal.
REQ-033 alu_seq instantiates alu_seq_decode; ALU itself is external.

Verification (bench connects alu_seq to the ALU)
REQ-034 AND a=a5a5a5a5, b=5a5a5a5a -> rsp_result 00000000, zero 1, carry 0, ovf 0; rsp_valid 2 edges after accept.
REQ-035 OR then ADD same operands -> ffffffff, zero 0; ADD carry 0, ovf 0.
REQ-036 SUB a=a5a5a5a5, b=5a5a5a5a -> 4b4b4b4b, carry 1, ovf 1; Binvert 1, Carryin 1 seen at ALU during EXEC.
REQ-037 SLT (macro on) a=ffffffff, b=00000001 -> 00000001; a=7fffffff, b=80000000 -> 00000000; macro off -> rsp_err 1, result 0.
REQ-038 rsp_ready low 5 cycles in RESP with cmd_valid high -> rsp_* stable, cmd_ready 0; handshake then IDLE, next command accepted.
REQ-039 reset asserted during EXEC -> no rsp_valid, all outputs 0, cmd_ready 1 next cycle; opcode 011 -> rsp_err 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, ALU select codes and FSM states.
// SLT support is controlled by the ALU_SEQ_SLT_EN macro in the files that import this package.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder producing the external ALU controls and an illegal-opcode flag.
// Opcode 111 decodes as SLT only when ALU_SEQ_SLT_EN is defined.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] cmd_op,
    output logic [1:0] operation,
    output logic       binvert,
    output logic       carryin,
    output logic       illegal
);

    // Illegal opcodes fall back to an AND with no inversion so the ALU sees benign controls.
    always_comb begin
        operation = ALU_AND;
        binvert   = 1'b0;
        carryin   = 1'b0;
        illegal   = 1'b0;
        case (cmd_op)
            OP_AND: operation = ALU_AND;
            OP_OR:  operation = ALU_OR;
            OP_ADD: operation = ALU_ADD;
            OP_SUB: begin
                operation = ALU_ADD;
                binvert   = 1'b1;
                carryin   = 1'b1;
            end
`ifdef ALU_SEQ_SLT_EN
            OP_SLT: begin
                operation = ALU_ADD;
                binvert   = 1'b1;
                carryin   = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Three-state sequencer that registers a command into an external ALU and returns flags.
// Define ALU_SEQ_SLT_EN to enable opcode 111 (set-less-than); otherwise it is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             Binvert,
    output logic             Carryin,
    output logic [1:0]       Operation,
    input  logic [WIDTH-1:0] Result,
    input  logic             CarryOut,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_err
);

    state_t           state;
    logic [1:0]       dec_operation;
    logic             dec_binvert;
    logic             dec_carryin;
    logic             dec_illegal;
    logic             illegal_q;
    logic             arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] exec_result;
    logic             exec_carry;
    logic             exec_ovf;
    logic             exec_zero;
`ifdef ALU_SEQ_SLT_EN
    logic             slt_q;
`endif

    alu_seq_decode u_decode (
        .cmd_op    (cmd_op),
        .operation (dec_operation),
        .binvert   (dec_binvert),
        .carryin   (dec_carryin),
        .illegal   (dec_illegal)
    );

    // Only the adder path (ADD/SUB/SLT) reports carry and overflow.
    assign arith = (Operation == ALU_ADD) && !illegal_q;
    assign b_eff = Binvert ? ~b : b;

    always_comb begin
        exec_result = Result;
        exec_carry  = arith & CarryOut;
        exec_ovf    = arith & (a[WIDTH-1] == b_eff[WIDTH-1]) & (Result[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SEQ_SLT_EN
        if (slt_q) begin
            exec_result = {{(WIDTH-1){1'b0}}, Result[WIDTH-1] ^ exec_ovf};
        end
`endif
        if (illegal_q) begin
            exec_result = '0;
            exec_carry  = 1'b0;
            exec_ovf    = 1'b0;
        end
        exec_zero = !illegal_q && (exec_result == '0);
    end

    // Response registers are written once in EXEC and then held untouched through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            a          <= '0;
            b          <= '0;
            Binvert    <= 1'b0;
            Carryin    <= 1'b0;
            Operation  <= ALU_AND;
            illegal_q  <= 1'b0;
`ifdef ALU_SEQ_SLT_EN
            slt_q      <= 1'b0;
`endif
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a         <= cmd_a;
                        b         <= cmd_b;
                        Binvert   <= dec_binvert;
                        Carryin   <= dec_carryin;
                        Operation <= dec_operation;
                        illegal_q <= dec_illegal;
`ifdef ALU_SEQ_SLT_EN
                        slt_q     <= (cmd_op == OP_SLT);
`endif
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= exec_result;
                    rsp_carry  <= exec_carry;
                    rsp_zero   <= exec_zero;
                    rsp_ovf    <= exec_ovf;
                    rsp_err    <= illegal_q;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU attached, results compared against signed/unsigned arithmetic.
// Expectations for opcode 111 follow whether ALU_SEQ_SLT_EN is defined.
module tb_alu_seq;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         ovf;
        logic         err;
        logic         binv;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         Binvert;
    logic         Carryin;
    logic [1:0]   Operation;
    logic [W-1:0] Result;
    logic         CarryOut;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         rsp_ovf;
    logic         rsp_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .a          (a),
        .b          (b),
        .Binvert    (Binvert),
        .Carryin    (Carryin),
        .Operation  (Operation),
        .Result     (Result),
        .CarryOut   (CarryOut),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err)
    );

    // External ALU: AND / OR / adder with optional b inversion and carry-in.
    logic [W-1:0] alu_b;
    logic [W:0]   alu_sum;
    assign alu_b    = Binvert ? ~b : b;
    assign alu_sum  = {1'b0, a} + {1'b0, alu_b} + {{W{1'b0}}, Carryin};
    assign Result   = (Operation == 2'b00) ? (a & alu_b) :
                      (Operation == 2'b01) ? (a | alu_b) : alu_sum[W-1:0];
    assign CarryOut = alu_sum[W];

    function automatic bit slt_enabled();
`ifdef ALU_SEQ_SLT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        longint ex;
        logic [W:0] s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e  = '0;
        case (op)
            3'b000: e.res = x & y;
            3'b001: e.res = x | y;
            3'b010: begin
                s       = {1'b0, x} + {1'b0, y};
                e.res   = s[W-1:0];
                e.carry = s[W];
                ex      = sx + sy;
                e.ovf   = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
            end
            3'b110, 3'b111: begin
                if (op == 3'b111 && !slt_enabled()) begin
                    e.err = 1'b1;
                end else begin
                    e.binv  = 1'b1;
                    e.carry = (x >= y);
                    ex      = sx - sy;
                    e.ovf   = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
                    e.res   = (op == 3'b110) ? (x - y) : ((sx < sy) ? 32'd1 : 32'd0);
                end
            end
            default: e.err = 1'b1;
        endcase
        e.zero = !e.err && (e.res == '0);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full command/response transaction; stall cycles hold rsp_ready low in RESP with cmd_valid high.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int stall);
        exp_t e;
        int   waited;
        e = model(op, x, y);
        waited = 0;
        while (!cmd_ready && waited < 10) begin
            tick();
            waited++;
        end
        checkOutput("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = x;
        cmd_b     = y;
        tick();
        cmd_valid = 1'b0;
        checkOutput("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("exec_binvert", {31'd0, Binvert}, {31'd0, e.binv});
        checkOutput("exec_carryin", {31'd0, Carryin}, {31'd0, e.binv});
        tick();
        checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("rsp_result", rsp_result, e.res);
        checkOutput("rsp_flags", {28'd0, rsp_carry, rsp_zero, rsp_ovf, rsp_err},
                    {28'd0, e.carry, e.zero, e.ovf, e.err});
        cmd_valid = (stall > 0);
        cmd_op    = 3'b001;
        cmd_a     = ~x;
        for (int i = 0; i < stall; i++) begin
            tick();
            checkOutput("stall_result", rsp_result, e.res);
            checkOutput("stall_hs", {30'd0, rsp_valid, cmd_ready}, 32'd2);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("idle_hs", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    initial begin
        exp_t rnd;
        logic [2:0] rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'b010;
        cmd_a     = 32'h1234_5678;
        cmd_b     = 32'h1;
        rsp_ready = 1'b1;
        tick();
        tick();
        checkOutput("reset_ctrl", {28'd0, cmd_ready, rsp_valid, Operation}, 32'h8);
        checkOutput("reset_a", a, 32'd0);
        checkOutput("reset_rsp", {rsp_result[27:0], rsp_carry, rsp_zero, rsp_ovf, rsp_err}, 32'd0);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();

        applyStimulus(3'b000, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
        applyStimulus(3'b001, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
        applyStimulus(3'b010, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
        applyStimulus(3'b110, 32'ha5a5a5a5, 32'h5a5a5a5a, 5);
        applyStimulus(3'b111, 32'hffffffff, 32'h00000001, 0);
        applyStimulus(3'b111, 32'h7fffffff, 32'h80000000, 0);
        applyStimulus(3'b011, 32'h0000_0005, 32'h0000_0003, 0);
        applyStimulus(3'b010, 32'h7fffffff, 32'h00000001, 0);
        applyStimulus(3'b110, 32'h00000005, 32'h00000005, 0);

        // Reset in EXEC drops the command.
        cmd_valid = 1'b1;
        cmd_op    = 3'b010;
        cmd_a     = 32'h0000_0011;
        cmd_b     = 32'h0000_0022;
        tick();
        cmd_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_exec_ctrl", {28'd0, cmd_ready, rsp_valid, Operation}, 32'h8);
        checkOutput("rst_exec_ab", a | b, 32'd0);
        tick();
        tick();
        checkOutput("rst_exec_norsp", {30'd0, rsp_valid, cmd_ready}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? ra : $urandom;
            if (i % 6 == 1) ra = 32'h8000_0000;
            rnd = model(rop, ra, rb);
            if (rnd.err && rop != 3'b111 && rop != 3'b011 && rop[2:1] != 2'b10) begin
                $display("[TB] illegal opcode %0d exercised", rop);
            end
            applyStimulus(rop, ra, rb, i % 3);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
